// File: rtl/button_repeat_encoder.sv
// Typematic encoder for a debounced button: step on press, auto-repeat while held,
// one-shot long-press flag and a saturating repeat counter.
module button_repeat_encoder #(
    parameter int unsigned INIT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD = 10000000,
    parameter int unsigned LONG_PRESS    = 100000000,
    parameter int unsigned CW            = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       level,
    output logic       step,
    output logic       held,
    output logic       long_press,
    output logic [7:0] repeat_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_REPEAT
    } state_t;

    localparam logic [CW-1:0] INIT_LAST   = CW'(INIT_DELAY - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_PRESS - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic          long_done_q, long_done_d;
    logic          level_q;
    logic          step_q, step_d;
    logic          held_q, held_d;
    logic          long_press_q, long_press_d;
    logic [7:0]    repeat_count_q, repeat_count_d;
    logic          rise;

    assign rise = level & ~level_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        hold_cnt_d     = hold_cnt_q;
        long_done_d    = long_done_q;
        step_d         = 1'b0;
        long_press_d   = 1'b0;
        repeat_count_d = repeat_count_q;

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    step_d         = 1'b1;
                    state_d        = S_WAIT;
                    cnt_d          = '0;
                    hold_cnt_d     = '0;
                    long_done_d    = 1'b0;
                    repeat_count_d = '0;
                end
            end
            S_WAIT, S_REPEAT: begin
                // Release takes priority over any step or long-press due this cycle.
                if (!level) begin
                    state_d = S_IDLE;
                end else begin
                    if (cnt_q == ((state_q == S_WAIT) ? INIT_LAST : REPEAT_LAST)) begin
                        step_d         = 1'b1;
                        cnt_d          = '0;
                        state_d        = S_REPEAT;
                        repeat_count_d = (repeat_count_q == 8'hFF) ? repeat_count_q
                                                                    : repeat_count_q + 8'd1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end

                    if (!long_done_q) begin
                        if (hold_cnt_q == LONG_LAST) begin
                            long_press_d = 1'b1;
                            long_done_d  = 1'b1;
                        end else begin
                            hold_cnt_d = hold_cnt_q + CW'(1);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        held_d = (state_d != S_IDLE);
    end

    // level_q resets high so a button already held at reset release is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            hold_cnt_q     <= '0;
            long_done_q    <= 1'b0;
            level_q        <= 1'b1;
            step_q         <= 1'b0;
            held_q         <= 1'b0;
            long_press_q   <= 1'b0;
            repeat_count_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            hold_cnt_q     <= hold_cnt_d;
            long_done_q    <= long_done_d;
            level_q        <= level;
            step_q         <= step_d;
            held_q         <= held_d;
            long_press_q   <= long_press_d;
            repeat_count_q <= repeat_count_d;
        end
    end

    assign step         = step_q;
    assign held         = held_q;
    assign long_press   = long_press_q;
    assign repeat_count = repeat_count_q;

endmodule

// File: tb/tb_button_repeat_encoder.sv
// Directed scoreboard bench for button_repeat_encoder with small timing parameters.
module tb_button_repeat_encoder;

    logic       clk;
    logic       rst_n;
    logic       level;
    logic       step;
    logic       held;
    logic       long_press;
    logic [7:0] repeat_count;

    int tests;
    int fails;

    typedef struct {
        logic       step;
        logic       held;
        logic       lp;
        logic [7:0] rc;
        string      tag;
    } exp_t;

    exp_t sb[$];

    button_repeat_encoder #(
        .INIT_DELAY(4),
        .REPEAT_PERIOD(2),
        .LONG_PRESS(10),
        .CW(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .level(level),
        .step(step),
        .held(held),
        .long_press(long_press),
        .repeat_count(repeat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_now(input string tag, input logic es, input logic eh,
                             input logic elp, input logic [7:0] erc);
        tests++;
        assert (step === es) else begin
            fails++;
            $error("FAIL %s.step: got %b expected %b", tag, step, es);
        end
        tests++;
        assert (held === eh) else begin
            fails++;
            $error("FAIL %s.held: got %b expected %b", tag, held, eh);
        end
        tests++;
        assert (long_press === elp) else begin
            fails++;
            $error("FAIL %s.long_press: got %b expected %b", tag, long_press, elp);
        end
        tests++;
        assert (repeat_count === erc) else begin
            fails++;
            $error("FAIL %s.repeat_count: got %0d expected %0d", tag, repeat_count, erc);
        end
    endtask

    // Drive level for one edge, queue the expected outputs, then check just after the edge.
    task automatic tick(input logic lvl, input logic es, input logic eh,
                        input logic elp, input logic [7:0] erc, input string tag);
        exp_t e;
        @(negedge clk);
        level = lvl;
        e.step = es; e.held = eh; e.lp = elp; e.rc = erc; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_now(e.tag, e.step, e.held, e.lp, e.rc);
    endtask

    // Expected values k edges after the press edge, INIT_DELAY=4, REPEAT_PERIOD=2, LONG_PRESS=10.
    function automatic logic exp_step(input int k);
        return (k == 0) || (k >= 4 && (k % 2) == 0);
    endfunction

    function automatic logic [7:0] exp_rc(input int k);
        int v;
        v = (k < 4) ? 0 : (k - 4) / 2 + 1;
        if (v > 255) v = 255;
        return 8'(v);
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        level = 1'b0;
        rst_n = 1'b0;
        #1;
        check_now("reset", 1'b0, 1'b0, 1'b0, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "idle");

        // Long hold through several repeats and the long-press point
        for (int k = 0; k <= 10; k++)
            tick(1'b1, exp_step(k), 1'b1, k == 10, exp_rc(k), $sformatf("hold_k%0d", k));
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd4, "hold_release");
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd4, "hold_idle");

        // Tap
        tick(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, "tap_k0");
        tick(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, "tap_k1");
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "tap_release");
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "tap_idle");

        // Release exactly at the first-repeat edge
        for (int k = 0; k <= 3; k++)
            tick(1'b1, k == 0, 1'b1, 1'b0, 8'd0, $sformatf("bnd_k%0d", k));
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "bnd_k4");
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "bnd_idle");

        // Level already high across reset release
        @(negedge clk);
        level = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++)
            tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, $sformatf("rsthigh_%0d", k));
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "rsthigh_low");
        tick(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, "rsthigh_press");
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "rsthigh_release");

        // Very long hold: saturation and single long-press
        for (int k = 0; k < 600; k++)
            tick(1'b1, exp_step(k), 1'b1, k == 10, exp_rc(k), $sformatf("sat_k%0d", k));
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd255, "sat_release");
        tick(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, "repress_k0");

        // Asynchronous reset while in REPEAT with step high
        for (int k = 1; k <= 6; k++)
            tick(1'b1, exp_step(k), 1'b1, 1'b0, exp_rc(k), $sformatf("pre_async_k%0d", k));
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_reset", 1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++)
            tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, $sformatf("post_async_%0d", k));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
